// File: rtl/l1d_tag_match.sv
// L1D tag lookup pipeline: stage A issues the tag-RAM read and compares the
// returned ways, stage B holds the hit/multihit/way/victim result for the consumer.
module l1d_tag_match #(
  parameter int WAYS  = 4,
  parameter int TAG_W = 20,
  parameter int IDX_W = 6,
  localparam int WI   = $clog2(WAYS)
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_resetn_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [TAG_W-1:0]      req_tag_i,
  input  logic [IDX_W-1:0]      req_idx_i,
  output logic                  tag_rd_en_o,
  output logic [IDX_W-1:0]      tag_rd_idx_o,
  input  logic [WAYS*TAG_W-1:0] way_tag_i,
  input  logic [WAYS-1:0]       way_valid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_hit_o,
  output logic                  out_multihit_o,
  output logic [WI-1:0]         out_way_o,
  output logic [WI-1:0]         out_victim_o,
  output logic [TAG_W-1:0]      out_tag_o,
  output logic [IDX_W-1:0]      out_idx_o
);

  logic             a_valid_q, a_valid_d;
  logic             a_held_q, a_held_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;
  logic [IDX_W-1:0] a_idx_q, a_idx_d;
  logic [WAYS-1:0]  a_hitv_q, a_hitv_d;
  logic [WAYS-1:0]  a_wval_q, a_wval_d;

  logic             b_valid_q, b_valid_d;
  logic             b_hit_q, b_hit_d;
  logic             b_multi_q, b_multi_d;
  logic [WI-1:0]    b_way_q, b_way_d;
  logic [WI-1:0]    b_lowinv_q, b_lowinv_d;
  logic             b_allv_q, b_allv_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;
  logic [IDX_W-1:0] b_idx_q, b_idx_d;

  logic [WI-1:0]    rr_q, rr_d;

  logic [WAYS-1:0]  live_hitv;
  logic [WAYS-1:0]  src_hitv;
  logic [WAYS-1:0]  src_wval;
  logic [WI:0]      hit_cnt;
  logic [WI-1:0]    hit_way;
  logic [WI-1:0]    low_inv;
  logic             out_fire;
  logic             b_free;
  logic             a_move;
  logic             a_hold;
  logic             accept;

  // Live compare is only meaningful in the cycle after acceptance; once held,
  // the captured vectors stand in for the RAM data that is no longer valid.
  always_comb begin
    live_hitv = '0;
    for (int w = 0; w < WAYS; w++) begin
      live_hitv[w] = way_valid_i[w] & (way_tag_i[w*TAG_W +: TAG_W] == a_tag_q);
    end
  end

  assign src_hitv = a_held_q ? a_hitv_q : live_hitv;
  assign src_wval = a_held_q ? a_wval_q : way_valid_i;

  always_comb begin
    hit_cnt = '0;
    hit_way = '0;
    low_inv = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_cnt = hit_cnt + (WI+1)'(src_hitv[w]);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (src_hitv[w]) hit_way = WI'(w);
      if (!src_wval[w]) low_inv = WI'(w);
    end
  end

  assign out_fire    = b_valid_q & out_ready_i;
  assign b_free      = ~b_valid_q | out_ready_i;
  assign a_move      = a_valid_q & b_free;
  assign a_hold      = a_valid_q & ~a_held_q & ~b_free;
  assign req_ready_o = (~a_valid_q | a_move) & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;

  assign tag_rd_en_o  = accept;
  assign tag_rd_idx_o = req_idx_i;

  always_comb begin
    a_valid_d = a_valid_q;
    a_held_d  = a_held_q;
    a_tag_d   = a_tag_q;
    a_idx_d   = a_idx_q;
    a_hitv_d  = a_hitv_q;
    a_wval_d  = a_wval_q;
    if (flush_i) begin
      a_valid_d = 1'b0;
      a_held_d  = 1'b0;
    end else if (accept) begin
      a_valid_d = 1'b1;
      a_held_d  = 1'b0;
      a_tag_d   = req_tag_i;
      a_idx_d   = req_idx_i;
    end else if (a_move) begin
      a_valid_d = 1'b0;
      a_held_d  = 1'b0;
    end else if (a_hold) begin
      a_held_d  = 1'b1;
      a_hitv_d  = live_hitv;
      a_wval_d  = way_valid_i;
    end
  end

  always_comb begin
    b_valid_d  = b_valid_q;
    b_hit_d    = b_hit_q;
    b_multi_d  = b_multi_q;
    b_way_d    = b_way_q;
    b_lowinv_d = b_lowinv_q;
    b_allv_d   = b_allv_q;
    b_tag_d    = b_tag_q;
    b_idx_d    = b_idx_q;
    rr_d       = rr_q;
    if (flush_i) begin
      b_valid_d = 1'b0;
    end else begin
      if (out_fire && !b_hit_q && b_allv_q) rr_d = rr_q + WI'(1);
      if (a_move) begin
        b_valid_d  = 1'b1;
        b_hit_d    = (hit_cnt == (WI+1)'(1));
        b_multi_d  = (hit_cnt > (WI+1)'(1));
        b_way_d    = hit_way;
        b_lowinv_d = low_inv;
        b_allv_d   = &src_wval;
        b_tag_d    = a_tag_q;
        b_idx_d    = a_idx_q;
      end else if (out_fire) begin
        b_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      a_valid_q  <= 1'b0;
      a_held_q   <= 1'b0;
      a_tag_q    <= '0;
      a_idx_q    <= '0;
      a_hitv_q   <= '0;
      a_wval_q   <= '0;
      b_valid_q  <= 1'b0;
      b_hit_q    <= 1'b0;
      b_multi_q  <= 1'b0;
      b_way_q    <= '0;
      b_lowinv_q <= '0;
      b_allv_q   <= 1'b0;
      b_tag_q    <= '0;
      b_idx_q    <= '0;
      rr_q       <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_held_q   <= a_held_d;
      a_tag_q    <= a_tag_d;
      a_idx_q    <= a_idx_d;
      a_hitv_q   <= a_hitv_d;
      a_wval_q   <= a_wval_d;
      b_valid_q  <= b_valid_d;
      b_hit_q    <= b_hit_d;
      b_multi_q  <= b_multi_d;
      b_way_q    <= b_way_d;
      b_lowinv_q <= b_lowinv_d;
      b_allv_q   <= b_allv_d;
      b_tag_q    <= b_tag_d;
      b_idx_q    <= b_idx_d;
      rr_q       <= rr_d;
    end
  end

  // The victim follows the live pointer so successive all-valid misses see each advance.
  assign out_valid_o    = b_valid_q;
  assign out_hit_o      = b_hit_q;
  assign out_multihit_o = b_multi_q;
  assign out_way_o      = b_way_q;
  assign out_victim_o   = b_allv_q ? rr_q : b_lowinv_q;
  assign out_tag_o      = b_tag_q;
  assign out_idx_o      = b_idx_q;

endmodule

// File: doc/l1d_tag_match.md
L1D_TAG_MATCH -- requirements
Module: l1d_tag_match

Interface
REQ-001 Parameters SHALL be: WAYS, default 4, number of L1D ways (power of two, >=2); TAG_W, default 20, tag width; IDX_W, default 6, set-index width; WI = $clog2(WAYS).
REQ-002 cpu_clock_i  in  1  sole clock; all state on rising edge.
REQ-003 cpu_resetn_i  in  1  asynchronous active-low reset.
REQ-004 flush_i  in  1  synchronous pipeline flush.
REQ-005 req_valid_i / req_ready_o  in/out  1/1  lookup request handshake.
REQ-006 req_tag_i, req_idx_i  in  TAG_W, IDX_W  lookup tag and set index.
REQ-007 tag_rd_en_o, tag_rd_idx_o  out  1, IDX_W  tag-RAM read port (synchronous RAM, data next cycle).
REQ-008 way_tag_i, way_valid_i  in  WAYS*TAG_W, WAYS  tag-RAM read data, valid only the cycle after tag_rd_en_o.
REQ-009 out_valid_o / out_ready_i  out/in  1/1  result handshake.
REQ-010 out_hit_o, out_multihit_o  out  1, 1  exactly-one-hit; more-than-one-hit error.
REQ-011 out_way_o, out_victim_o  out  WI, WI  hitting way; replacement way.
REQ-012 out_tag_o, out_idx_o  out  TAG_W, IDX_W  echoed request fields.

Function
REQ-013 Stages SHALL be: A (request registered, RAM read in flight, optional hit-vector hold) and B (result register driving out_*).
REQ-014 Request SHALL be accepted on req_valid_i & req_ready_o & !flush_i; same cycle tag_rd_en_o=1, tag_rd_idx_o=req_idx_i; tag_rd_en_o SHALL be 0 otherwise.
REQ-015 Hit vector bit w SHALL be way_valid_i[w] & (way_tag_i[w*TAG_W +: TAG_W]==A tag), computed only in the cycle after acceptance (compare cycle).
REQ-016 In the compare cycle, if B empty or (out_valid_o & out_ready_i), result SHALL load B directly and A frees; else hit vector and way_valid_i SHALL be captured in A hold and A stays occupied.
REQ-017 Held A entry SHALL move to B on the first cycle B is empty or draining.
REQ-018 req_ready_o SHALL be 1 when A is empty, or A frees this cycle (REQ-016/017), and flush_i=0; back-to-back requests SHALL sustain one lookup per cycle when out_ready_i=1.
REQ-019 Load latency: request accepted cycle t SHALL present out_valid_o at t+2 with no backpressure.
REQ-020 out_hit_o = hit vector has exactly one bit set; out_multihit_o = more than one bit set; out_hit_o=0 when multihit.
REQ-021 out_way_o SHALL be index of lowest set hit bit (0 if none).
REQ-022 out_victim_o SHALL be lowest-index way with valid=0; if all valid, the round-robin pointer value; meaningful only when out_hit_o=0.
REQ-023 Round-robin pointer SHALL increment (wrap WAYS-1 -> 0) on each out handshake with out_hit_o=0 and all ways valid; otherwise hold.
REQ-024 B SHALL hold all out_* stable while out_valid_o=1 & out_ready_i=0.
REQ-025 flush_i SHALL clear A and B valid next edge, discard in-flight RAM data, leave pointer unchanged; flush has priority over accept and transfer.

Reset
REQ-026 On cpu_resetn_i low: A/B valid=0, out_valid_o=0, req_ready_o=1 after release, all out_* data=0, tag_rd_en_o=0, pointer=0.
REQ-027 Reset asserted mid-lookup SHALL drop all in-flight requests with no output produced.

Verification
REQ-028 WAYS=4; req tag 0x123, RAM way2 tag 0x123 valid, others differ -> at t+2 out_hit=1, way=2, multihit=0.
REQ-029 Tags 0x55 valid in ways 1 and 3 -> out_hit=0, multihit=1, way=1.
REQ-030 Miss, way_valid=4'b1011 -> victim=2; miss with all valid on 5 successive fires -> victims 0,1,2,3,0.
REQ-031 out_ready_i=0 for 3 cycles with two requests issued -> second held in A, req_ready_o=0, results emerge in order unchanged once ready.
REQ-032 flush_i in compare cycle with B full -> out_valid_o=0 next cycle, no result emitted for either request, pointer unchanged.
REQ-033 Continuous requests, out_ready_i=1 -> one result per cycle, tag_rd_en_o high every cycle.
